// File: rtl/bo_mult_control_unit_if.sv
// Control/handshake bundle between the multiplier sequencer and its host/datapath.
// The master drives start and the datapath flags; the slave (sequencer) drives y, busy, done.
interface bo_mult_control_unit_if;
  logic        start;
  logic [2:0]  f;
  logic [10:1] y;
  logic        busy;
  logic        done;

  modport master (
    output start,
    output f,
    input  y,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  f,
    output y,
    output busy,
    output done
  );
endinterface

// File: rtl/bo_mult_control_unit.sv
// Moore sequencer for the ones'-complement MSB-first shift-and-add multiplier.
// Optional macro NEGZERO_FIX_EN builds the CHECK/FIX states that turn a -0 result into +0.
module bo_mult_control_unit #(
  parameter int unsigned N = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  bo_mult_control_unit_if.slave  bus
);

  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StLoad  = 4'd1,
    StShift = 4'd2,
    StAddP  = 4'd3,
    StAddN  = 4'd4,
    StStep  = 4'd5,
    StFlag  = 4'd6,
    StDone  = 4'd7
`ifdef NEGZERO_FIX_EN
    ,
    StCheck = 4'd8,
    StFix   = 4'd9
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StLoad;
      StLoad: begin
        cnt_d   = CntW'(N - 1);
        state_d = StShift;
      end
      // f[1]^f[0] set means the analysed bit differs from the sign: add A (or ~A if negative).
      StShift: begin
        if (bus.f[1] ^ bus.f[0]) state_d = bus.f[0] ? StAddN : StAddP;
        else                     state_d = StStep;
      end
      StAddP:  state_d = StStep;
      StAddN:  state_d = StStep;
      StStep: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
`ifdef NEGZERO_FIX_EN
          state_d = StCheck;
`else
          state_d = StFlag;
`endif
        end else begin
          state_d = StShift;
        end
      end
`ifdef NEGZERO_FIX_EN
      StCheck: state_d = bus.f[2] ? StFix : StFlag;
      StFix:   state_d = StFlag;
`endif
      StFlag:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are a pure function of the state register.
  always_comb begin
    bus.y    = '0;
    bus.busy = (state_q != StIdle);
    bus.done = 1'b0;
    case (state_q)
      StLoad: begin
        bus.y[1] = 1'b1;
        bus.y[2] = 1'b1;
        bus.y[3] = 1'b1;
        bus.y[8] = 1'b1;
      end
      StShift: bus.y[7] = 1'b1;
      StAddP: begin
        bus.y[4] = 1'b1;
        bus.y[6] = 1'b1;
        bus.y[7] = 1'b1;
        bus.y[9] = 1'b1;
      end
      StAddN: begin
        bus.y[5] = 1'b1;
        bus.y[6] = 1'b1;
        bus.y[7] = 1'b1;
        bus.y[9] = 1'b1;
      end
      StStep:  bus.y[3] = 1'b1;
`ifdef NEGZERO_FIX_EN
      StFix:   bus.y[8] = 1'b1;
`endif
      StFlag:  bus.y[10] = 1'b1;
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bo_mult_control_unit.sv
// Bench for bo_mult_control_unit with a small N=4 ones'-complement datapath model.
// Checks the per-cycle control word against hand-built state sequences and the final product.
module tb_bo_mult_control_unit;

  localparam logic [9:0] YIdle  = 10'h000;
  localparam logic [9:0] YLoad  = 10'h087;  // y1 y2 y3 y8
  localparam logic [9:0] YShift = 10'h040;  // y7
  localparam logic [9:0] YAddP  = 10'h168;  // y4 y6 y7 y9
  localparam logic [9:0] YAddN  = 10'h170;  // y5 y6 y7 y9
  localparam logic [9:0] YStep  = 10'h004;  // y3
  localparam logic [9:0] YFix   = 10'h080;  // y8
  localparam logic [9:0] YFlag  = 10'h200;  // y10

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bo_mult_control_unit_if bus_if ();

  bo_mult_control_unit #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Datapath model: RA, RB, 2N-bit rr with end-around-carry addition.
  logic [3:0] a_in, b_in, ra, rb;
  logic [7:0] rr, opnd;
  logic [8:0] sum;

  always_comb begin
    opnd = bus_if.y[4] ? {{4{ra[3]}}, ra} : ~{{4{ra[3]}}, ra};
    sum  = {1'b0, rr} + {1'b0, opnd};
  end

  always @(posedge clk) begin
    if (bus_if.y[1]) ra <= a_in;
    if (bus_if.y[2])      rb <= b_in;
    else if (bus_if.y[3]) rb <= {rb[3], rb[1:0], 1'b0};
    if (bus_if.y[8])      rr <= 8'h00;
    else if (bus_if.y[9]) rr <= sum[7:0] + {7'b0, sum[8]};
    else if (bus_if.y[7]) rr <= {rr[6:0], rr[7]};
  end

  assign bus_if.f = {&rr[4:0], rb[2], rb[3]};

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // op: 0 = no add, 1 = ADD_P, 2 = ADD_N, per iteration in MSB-first order.
  task automatic build_seq(input int op0, input int op1, input int op2, input bit negzero);
    int ops[3];
    ops = '{op0, op1, op2};
    exp_q.delete();
    exp_q.push_back(YLoad);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(YShift);
      if (ops[i] == 1) exp_q.push_back(YAddP);
      if (ops[i] == 2) exp_q.push_back(YAddN);
      exp_q.push_back(YStep);
    end
`ifdef NEGZERO_FIX_EN
    exp_q.push_back(YIdle);  // CHECK
    if (negzero) exp_q.push_back(YFix);
`else
    if (negzero) exp_q.push_back(YIdle);  // keeps the argument meaningful in both builds
    if (negzero) void'(exp_q.pop_back());
`endif
    exp_q.push_back(YFlag);
    exp_q.push_back(YIdle);  // DONE
  endtask

  task automatic run_mult(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] rr_exp, input bit retrig);
    int n;
    n = exp_q.size();
    @(negedge clk);
    a_in = a;
    b_in = b;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s y c%0d", tag, i + 1), 32'(bus_if.y), 32'(exp_q[i]));
      check_eq($sformatf("%s busy c%0d", tag, i + 1), 32'(bus_if.busy), 32'd1);
      check_eq($sformatf("%s done c%0d", tag, i + 1), 32'(bus_if.done), 32'(i == n - 1));
      bus_if.start = retrig && (i == 2 || i == 5);
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    check_eq({tag, " idle y"}, 32'(bus_if.y), 32'd0);
    check_eq({tag, " idle busy"}, 32'(bus_if.busy), 32'd0);
    check_eq({tag, " rr"}, 32'(rr), 32'(rr_exp));
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.start = 1'b1;
    a_in = 4'h0;
    b_in = 4'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("rst y", 32'(bus_if.y), 32'd0);
      check_eq("rst busy", 32'(bus_if.busy), 32'd0);
      check_eq("rst done", 32'(bus_if.done), 32'd0);
    end
    bus_if.start = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("post-rst idle busy", 32'(bus_if.busy), 32'd0);
      check_eq("post-rst idle y", 32'(bus_if.y), 32'd0);
    end

    build_seq(0, 1, 0, 1'b0);
    run_mult("3x2", 4'b0011, 4'b0010, 8'b0000_0110, 1'b0);

    build_seq(0, 2, 0, 1'b0);
    run_mult("3x-2", 4'b0011, 4'b1101, 8'b1111_1001, 1'b0);

    build_seq(0, 0, 2, 1'b1);
`ifdef NEGZERO_FIX_EN
    run_mult("0x-1", 4'b0000, 4'b1110, 8'b0000_0000, 1'b0);
`else
    run_mult("0x-1", 4'b0000, 4'b1110, 8'b1111_1111, 1'b0);
`endif

    build_seq(0, 1, 1, 1'b0);
    run_mult("5x3", 4'b0101, 4'b0011, 8'b0000_1111, 1'b0);

    build_seq(0, 1, 0, 1'b0);
    run_mult("retrig", 4'b0011, 4'b0010, 8'b0000_0110, 1'b1);

    // Abort in ADD_P with a synchronous reset, then run a full multiplication.
    @(negedge clk);
    a_in = 4'b0011;
    b_in = 4'b0010;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("abort in addp", 32'(bus_if.y), 32'(YAddP));
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort y", 32'(bus_if.y), 32'd0);
    check_eq("abort busy", 32'(bus_if.busy), 32'd0);
    check_eq("abort done", 32'(bus_if.done), 32'd0);
    rst_n = 1'b1;
    build_seq(0, 1, 0, 1'b0);
    run_mult("after abort", 4'b0011, 4'b0010, 8'b0000_0110, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
